eu_icon_fetch: RTL and testbench
================================

EU_ICON_FETCH -- requirements
Module: eu_icon_fetch

Interface
REQ-001 Parameter ADDR_W, default 8, exec-unit cache address width.
REQ-002 Parameter DATA_W, default 16, exec-unit operand data width.
REQ-003 Parameter RETRY_GAP, default 2, idle cycles between a failed read and the next attempt (legal 1..15).
REQ-004 Parameter MAX_RETRY, default 15, failed attempts before abort (legal 1..255; used only with REQ-031).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid_i  in  1  fetch request present.
REQ-008 req_ready_o  out  1  fetch request accepted when high with req_valid_i.
REQ-009 req_addr_i  in  ADDR_W  source cache address to fetch.
REQ-010 req_tag_i  in  1  destination operand slot (0 = op0, 1 = op1).
REQ-011 icon_raddr_o  out  ADDR_W  interconnect read address to source exec-unit cache.
REQ-012 icon_rvalid_o  out  1  interconnect read attempt this cycle.
REQ-013 icon_rdata_i  in  DATA_W  read data from cache, sampled only when icon_rsuccess_i high.
REQ-014 icon_rsuccess_i  in  1  cache reports hit/valid data in the same cycle as icon_rvalid_o.
REQ-015 tx_valid_o  out  1  fetched operand available toward destination unit.
REQ-016 tx_ready_i  in  1  destination accepts operand.
REQ-017 tx_data_o / tx_addr_o / tx_tag_o  out  DATA_W / ADDR_W / 1  fetched data, its source address, its slot tag.
REQ-018 busy_o  out  1  high in any state other than IDLE.
REQ-019 err_o  out  1  one-cycle abort pulse (REQ-031).

Function
REQ-020 FSM states SHALL be IDLE, READ, GAP, SEND.
REQ-021 IDLE: req_ready_o=1; on req_valid_i, latch req_addr_i and req_tag_i, go READ next cycle; no other state asserts req_ready_o.
REQ-022 READ: icon_rvalid_o=1, icon_raddr_o=latched address; icon_rvalid_o=0 and icon_raddr_o=0 in all other states.
REQ-023 READ with icon_rsuccess_i=1: capture icon_rdata_i, go SEND; latency accept-to-tx_valid_o = 2 cycles on first-attempt success.
REQ-024 READ with icon_rsuccess_i=0: go GAP, load gap counter with RETRY_GAP.
REQ-025 GAP: decrement counter each cycle; on reaching 0 go READ (i.e. exactly RETRY_GAP cycles with icon_rvalid_o low between attempts).
REQ-026 SEND: tx_valid_o=1 with tx_data_o/tx_addr_o/tx_tag_o stable until tx_ready_i=1; on handshake go IDLE.
REQ-027 tx_ready_i high outside SEND SHALL be ignored; icon_rsuccess_i/icon_rdata_i outside READ SHALL be ignored.
REQ-028 One request in flight; a new request SHALL be accepted no earlier than the cycle after the SEND handshake (one-cycle IDLE bubble).
REQ-029 tx_* data outputs SHALL hold last captured values outside SEND; only tx_valid_o qualifies them.

Reset
REQ-030 reset high at any clock edge, including mid-READ/GAP/SEND, SHALL force IDLE, drop the in-flight request, and clear all registers: tx_valid_o=0, tx_data_o=0, tx_addr_o=0, tx_tag_o=0, icon_rvalid_o=0, icon_raddr_o=0, busy_o=0, err_o=0, counters=0; req_ready_o=1 from the first cycle after reset deasserts.

Configuration
REQ-031 Macro EU_ICON_FETCH_TIMEOUT_EN defined: retry counter increments per failed READ; when it equals MAX_RETRY, go IDLE instead of GAP, pulse err_o for exactly one cycle, discard request (no tx_valid_o); counter clears on every new accept.
REQ-032 Macro undefined: retries unbounded, no retry counter, err_o tied 0.

Verification
REQ-033 Addr 0x12 tag 1, cache succeeds first attempt with data 0xBEEF, tx_ready_i=1 -> icon_rvalid_o one cycle at accept+1, tx_valid_o at accept+2 with 0xBEEF/0x12/1, req_ready_o high at accept+3.
REQ-034 Cache fails 3 attempts then succeeds, RETRY_GAP=2 -> icon_rvalid_o pulses at accept+1, +4, +7, +10; tx_valid_o at accept+11.
REQ-035 Success with tx_ready_i low 5 cycles -> tx_valid_o and data stable all 5 cycles, req_ready_o low, handshake on 6th, IDLE next.
REQ-036 Reset asserted during GAP and during SEND -> next cycle all outputs zero, busy_o=0; fresh request then completes normally.
REQ-037 With EU_ICON_FETCH_TIMEOUT_EN, MAX_RETRY=4, cache always fails -> exactly 4 icon_rvalid_o pulses, single err_o pulse, tx_valid_o never high, req_ready_o high next cycle; without macro -> pulses continue, err_o stays 0.

Source files
------------

// File: rtl/eu_icon_fetch_if.sv
// Fetch-path interface for eu_icon_fetch: request intake, cache read port,
// and operand transfer toward the destination unit.
// slave  : view used by the fetch engine itself.
// master : view used by the surrounding logic (requester, cache, destination).
interface eu_icon_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // request intake
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_tag_i;

    // interconnect read port toward the source cache
    logic [ADDR_W-1:0] icon_raddr_o;
    logic              icon_rvalid_o;
    logic [DATA_W-1:0] icon_rdata_i;
    logic              icon_rsuccess_i;

    // operand transfer toward the destination unit
    logic              tx_valid_o;
    logic              tx_ready_i;
    logic [DATA_W-1:0] tx_data_o;
    logic [ADDR_W-1:0] tx_addr_o;
    logic              tx_tag_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_tag_i,
        input  icon_rdata_i, icon_rsuccess_i,
        input  tx_ready_i,
        output req_ready_o,
        output icon_raddr_o, icon_rvalid_o,
        output tx_valid_o, tx_data_o, tx_addr_o, tx_tag_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_tag_i,
        output icon_rdata_i, icon_rsuccess_i,
        output tx_ready_i,
        input  req_ready_o,
        input  icon_raddr_o, icon_rvalid_o,
        input  tx_valid_o, tx_data_o, tx_addr_o, tx_tag_o
    );
endinterface

// File: rtl/eu_icon_fetch.sv
// eu_icon_fetch: fetches one operand at a time from a source exec-unit cache
// over the interconnect, retrying after a fixed idle gap on a miss, and hands
// the result to the destination unit with a valid/ready handshake.
//
// Optional feature: define EU_ICON_FETCH_TIMEOUT_EN to bound the number of
// failed read attempts to MAX_RETRY; the request is then dropped and err_o
// pulses for one cycle. Without the macro a request retries forever and
// err_o is tied low.
//
// All outputs are registered; the FSM sets them on the transition into the
// state that owns them, so each output is valid for the whole cycle.
module eu_icon_fetch #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RETRY_GAP = 2,   // 1..15
    parameter int MAX_RETRY = 15   // 1..255, timeout build only
) (
    input  logic          clk,
    input  logic          reset,
    eu_icon_fetch_if.slave bus,
    output logic          busy_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;     // address of the request in flight
    logic              tag_q;      // slot tag of the request in flight
    logic [3:0]        gap_cnt;    // idle cycles left before the next attempt

`ifdef EU_ICON_FETCH_TIMEOUT_EN
    logic [7:0]        retry_cnt;  // failed attempts for the current request
    // True when the miss being handled in READ is the last one allowed.
    logic              retry_exhausted;
    assign retry_exhausted = (retry_cnt == 8'(MAX_RETRY - 1));
`else
    // MAX_RETRY only matters for the timeout build.
    logic              cfg_unused;
    assign cfg_unused = (MAX_RETRY != 0);
`endif

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            addr_q            <= '0;
            tag_q             <= 1'b0;
            gap_cnt           <= '0;
`ifdef EU_ICON_FETCH_TIMEOUT_EN
            retry_cnt         <= '0;
`endif
            bus.req_ready_o   <= 1'b1;
            bus.icon_rvalid_o <= 1'b0;
            bus.icon_raddr_o  <= '0;
            bus.tx_valid_o    <= 1'b0;
            bus.tx_data_o     <= '0;
            bus.tx_addr_o     <= '0;
            bus.tx_tag_o      <= 1'b0;
            busy_o            <= 1'b0;
            err_o             <= 1'b0;
        end else begin
            // err_o is a single-cycle pulse; only the abort path raises it.
            err_o <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q            <= bus.req_addr_i;
                        tag_q             <= bus.req_tag_i;
`ifdef EU_ICON_FETCH_TIMEOUT_EN
                        retry_cnt         <= '0;
`endif
                        state             <= READ;
                        bus.req_ready_o   <= 1'b0;
                        busy_o            <= 1'b1;
                        bus.icon_rvalid_o <= 1'b1;
                        bus.icon_raddr_o  <= bus.req_addr_i;
                    end
                end

                READ: begin
                    // A read attempt lasts exactly one cycle.
                    bus.icon_rvalid_o <= 1'b0;
                    bus.icon_raddr_o  <= '0;
                    if (bus.icon_rsuccess_i) begin
                        // tx_* are only written here so they hold between transfers.
                        bus.tx_data_o  <= bus.icon_rdata_i;
                        bus.tx_addr_o  <= addr_q;
                        bus.tx_tag_o   <= tag_q;
                        bus.tx_valid_o <= 1'b1;
                        state          <= SEND;
                    end else begin
`ifdef EU_ICON_FETCH_TIMEOUT_EN
                        retry_cnt <= retry_cnt + 8'd1;
                        if (retry_exhausted) begin
                            // Give up: drop the request without any transfer.
                            state           <= IDLE;
                            bus.req_ready_o <= 1'b1;
                            busy_o          <= 1'b0;
                            err_o           <= 1'b1;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 4'(RETRY_GAP);
                        end
`else
                        state   <= GAP;
                        gap_cnt <= 4'(RETRY_GAP);
`endif
                    end
                end

                GAP: begin
                    // Leaving when the count hits zero gives RETRY_GAP idle cycles.
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state             <= READ;
                        bus.icon_rvalid_o <= 1'b1;
                        bus.icon_raddr_o  <= addr_q;
                    end
                end

                SEND: begin
                    if (bus.tx_ready_i) begin
                        // Return to IDLE; the next accept is a cycle later.
                        bus.tx_valid_o  <= 1'b0;
                        state           <= IDLE;
                        bus.req_ready_o <= 1'b1;
                        busy_o          <= 1'b0;
                    end
                end

                default: begin
                    state           <= IDLE;
                    bus.req_ready_o <= 1'b1;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

    // Read strobe only ever appears while in READ.
    a_rvalid_in_read: assert property (@(posedge clk) disable iff (reset)
        bus.icon_rvalid_o |-> (state == READ));

    // Transfer valid tracks the SEND state exactly.
    a_txvalid_in_send: assert property (@(posedge clk) disable iff (reset)
        bus.tx_valid_o == (state == SEND));

    // Ready and busy are always complementary.
    a_ready_busy: assert property (@(posedge clk) disable iff (reset)
        bus.req_ready_o != busy_o);

endmodule

// File: tb/tb_eu_icon_fetch.sv
// Randomized bench for eu_icon_fetch. Each request is described at transaction
// level (miss count, data, destination back-pressure) and the expected timeline
// of every output is computed from those numbers with plain arithmetic.
module tb_eu_icon_fetch;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int G    = 2;
    localparam int MAXR = 4;
`ifdef EU_ICON_FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, err;

    eu_icon_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    eu_icon_fetch #(.ADDR_W(AW), .DATA_W(DW), .RETRY_GAP(G), .MAX_RETRY(MAXR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy_o(busy),
        .err_o (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // last operand handed out; tx_* must hold these outside SEND
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_tag  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_junk();
        bus.req_valid_i     = 1'b0;
        bus.req_addr_i      = AW'($urandom);
        bus.req_tag_i       = 1'($urandom);
        bus.icon_rsuccess_i = 1'($urandom);
        bus.icon_rdata_i    = DW'($urandom);
        bus.tx_ready_i      = 1'($urandom);
    endtask

    task automatic idle_chk(input string where);
        chk({where, ".ready"},  32'(bus.req_ready_o),   32'd1);
        chk({where, ".busy"},   32'(busy),              32'd0);
        chk({where, ".rvalid"}, 32'(bus.icon_rvalid_o), 32'd0);
        chk({where, ".raddr"},  32'(bus.icon_raddr_o),  32'd0);
        chk({where, ".txv"},    32'(bus.tx_valid_o),    32'd0);
        chk({where, ".err"},    32'(err),               32'd0);
        chk({where, ".txd"},    32'(bus.tx_data_o),     32'(prev_data));
        chk({where, ".txa"},    32'(bus.tx_addr_o),     32'(prev_addr));
        chk({where, ".txt"},    32'(bus.tx_tag_o),      32'(prev_tag));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            drive_junk();
            @(posedge clk);
            @(negedge clk);
            idle_chk("idle");
        end
    endtask

    // Apply reset for one edge from the current negedge, then release it.
    task automatic pulse_reset();
        drive_junk();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        prev_data = '0;
        prev_addr = '0;
        prev_tag  = 1'b0;
        idle_chk("rst");
    endtask

    // One request, entered and left on a negedge where the DUT is idle.
    // nfail: misses before the hit; rdy: cycles of back-pressure in SEND;
    // rst_at: cycle offset after which reset is applied (0 = never).
    task automatic run_txn(input logic [AW-1:0] addr, input logic tag, input int nfail,
                           input logic [DW-1:0] data, input int rdy, input int rst_at);
        int  g1, attempts, last_read, s, end_n;
        bit  aborted, rd_exp, txv_exp;
        g1        = G + 1;
        aborted   = TO_EN && (nfail >= MAXR);
        attempts  = aborted ? MAXR : nfail + 1;
        last_read = 1 + (attempts - 1) * g1;
        s         = last_read + 1;
        end_n     = aborted ? s : s + rdy + 1;

        drive_junk();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        bus.req_tag_i   = tag;
        @(posedge clk);
        @(negedge clk);

        for (int n = 1; n <= end_n; n++) begin
            rd_exp  = (n <= last_read) && ((n - 1) % g1 == 0);
            txv_exp = !aborted && (n >= s) && (n <= s + rdy);
            if (!aborted && n == s) begin
                prev_data = data;
                prev_addr = addr;
                prev_tag  = tag;
            end
            chk("rvalid", 32'(bus.icon_rvalid_o), 32'(rd_exp));
            chk("raddr",  32'(bus.icon_raddr_o),  rd_exp ? 32'(addr) : 32'd0);
            chk("txv",    32'(bus.tx_valid_o),    32'(txv_exp));
            chk("txd",    32'(bus.tx_data_o),     32'(prev_data));
            chk("txa",    32'(bus.tx_addr_o),     32'(prev_addr));
            chk("txt",    32'(bus.tx_tag_o),      32'(prev_tag));
            chk("busy",   32'(busy),              32'(n < end_n));
            chk("ready",  32'(bus.req_ready_o),   32'(n >= end_n));
            chk("err",    32'(err),               32'(aborted && n == end_n));

            if (n == rst_at && n < end_n) begin
                pulse_reset();
                return;
            end

            drive_junk();
            // competing requests while busy must be ignored
            bus.req_valid_i = (n < end_n) ? 1'($urandom) : 1'b0;
            if (rd_exp) begin
                bus.icon_rsuccess_i = !aborted && ((n - 1) / g1 == nfail);
                if (bus.icon_rsuccess_i) bus.icon_rdata_i = data;
            end
            if (txv_exp) bus.tx_ready_i = (n - s) >= rdy;
            if (n < end_n) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        drive_junk();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.txv",    32'(bus.tx_valid_o),    32'd0);
        chk("rst.rvalid", 32'(bus.icon_rvalid_o), 32'd0);
        chk("rst.busy",   32'(busy),              32'd0);
        chk("rst.txd",    32'(bus.tx_data_o),     32'd0);
        reset = 1'b0;
        idle_cycles(2);

        // first-attempt hit, no back-pressure
        run_txn(8'h12, 1'b1, 0, 16'hBEEF, 0, 0);
        // three misses then a hit
        run_txn(8'h34, 1'b0, 3, 16'h1234, 0, 0);
        // destination stalls for five cycles
        run_txn(8'h56, 1'b1, 0, 16'hCAFE, 5, 0);
        idle_cycles(1);
        // reset while waiting in GAP, then a clean request
        run_txn(8'h78, 1'b0, 2, 16'h5555, 0, 2);
        run_txn(8'h9A, 1'b1, 1, 16'hA5A5, 1, 0);
        // reset while holding an operand in SEND, then a clean request
        run_txn(8'hBC, 1'b1, 0, 16'h7777, 5, 3);
        run_txn(8'hDE, 1'b0, 0, 16'h0F0F, 0, 0);
        // cache never hits within the retry budget
        run_txn(8'hF0, 1'b1, 10, 16'h3333, 0, 0);
        idle_cycles(2);

        for (int t = 0; t < 40; t++) begin
            run_txn(AW'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
                    DW'($urandom), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net; every wait above is a fixed number of clock cycles.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
